// File: rtl/fire_wb_pkg.sv
// Shared definitions for the fire*_writeback blocks.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package fire_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  // Pixels per channel plane of a square feature map.
  function automatic int pix_no_f(input int wout);
    return wout * wout;
  endfunction

  // Address width for a channel-major activation RAM holding the whole layer.
  function automatic int addr_w_f(input int dsp_no, input int wout);
    return $clog2(dsp_no * wout * wout);
  endfunction

endpackage

// File: rtl/fire6_expand3_writeback.sv
// Purpose: capture the fire6 expand3x3 output vector and serialize it into the activation RAM, channel-major.
// Latency: sample at edge t -> writes ch 0..DSP_NO-1 registered at edges t+1..t+DSP_NO.
// Backpressure: none; a sample arriving mid-drain is dropped and flagged on the sticky overrun output.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   sample_in       one-cycle pulse, ofm_in valid this cycle
//   ofm_in          DSP_NO parallel activations, WIDTH bits each
//   ram_we/addr/wdata  registered single-port RAM write interface
//   busy            high while a captured vector is being drained
//   ram_feedback    sticky, every pixel of the layer has been written
//   overrun         sticky, sample_in arrived while draining
module fire6_expand3_writeback
  import fire_wb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 256,
  parameter int WOUT   = 16,
  parameter int ADDR_W = addr_w_f(DSP_NO, WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_in,
  input  logic [WIDTH-1:0]  ofm_in [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              busy,
  output logic              ram_feedback,
  output logic              overrun
);

  localparam int PIX_NO = pix_no_f(WOUT);
  localparam int CH_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PIX_W  = (PIX_NO > 1) ? $clog2(PIX_NO) : 1;

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(DSP_NO - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_NO - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(PIX_NO);

  wb_state_t         state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ADDR_W-1:0] addr_q, addr_d;      // address of the next word to write
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
  logic              fb_q, fb_d;
  logic              ov_q, ov_d;
  logic [WIDTH-1:0]  cap_q [0:DSP_NO-1];
  logic [WIDTH-1:0]  cap_d [0:DSP_NO-1];

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pix_d       = pix_q;
    addr_d      = addr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    fb_d        = fb_q;
    ov_d        = ov_q;
    cap_d       = cap_q;

    case (state_q)
      IDLE: begin
        if (sample_in) begin
          cap_d   = ofm_in;
          ch_d    = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        ram_we_d    = 1'b1;
        ram_wdata_d = cap_q[ch_q];
        ram_addr_d  = addr_q;
        // Includes the final write cycle: the producer must not collide there either.
        if (sample_in) ov_d = 1'b1;
        if (ch_q == CH_LAST) begin
          ch_d   = '0;
          pix_d  = pix_q + PIX_W'(1);
          // Channel-major layout: the next pixel starts at its own index in plane 0.
          addr_d = ADDR_W'(pix_q) + ADDR_W'(1);
          if (pix_q == PIX_LAST) begin
            state_d = DONE;
            fb_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ch_d   = ch_q + CH_W'(1);
          addr_d = addr_q + ADDR_STEP;
        end
      end

      DONE: begin
        // The producer's extra trailing pulse lands here and is discarded silently.
        fb_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      pix_q       <= '0;
      addr_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      fb_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pix_q       <= pix_d;
      addr_q      <= addr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      fb_q        <= fb_d;
      ov_q        <= ov_d;
    end
  end

  // Capture buffer content is meaningless until a sample lands, so it carries no reset.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign busy         = (state_q == DRAIN);
  assign ram_feedback = fb_q;
  assign overrun      = ov_q;

endmodule

// File: tb/tb_fire6_expand3_writeback.sv
// Bench for fire6_expand3_writeback: a small instance (DSP_NO=4, WOUT=2) for directed,
// table-driven and randomized checks, and a default-size instance for a full-layer run.
module tb_fire6_expand3_writeback;

  localparam int S_DSP = 4;
  localparam int S_PIX = 4;
  localparam int B_DSP = 256;
  localparam int B_PIX = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance
  logic        s_rst, s_sample, s_we, s_busy, s_fb, s_ov;
  logic [15:0] s_ofm [0:S_DSP-1];
  logic [3:0]  s_addr;
  logic [15:0] s_wdata;

  fire6_expand3_writeback #(.WIDTH(16), .DSP_NO(S_DSP), .WOUT(2)) u_small (
    .clk(clk), .rst(s_rst), .sample_in(s_sample), .ofm_in(s_ofm),
    .ram_we(s_we), .ram_addr(s_addr), .ram_wdata(s_wdata),
    .busy(s_busy), .ram_feedback(s_fb), .overrun(s_ov)
  );

  // Default-size instance
  logic        b_rst, b_sample, b_we, b_busy, b_fb, b_ov;
  logic [15:0] b_ofm [0:B_DSP-1];
  logic [15:0] b_addr;
  logic [15:0] b_wdata;

  fire6_expand3_writeback u_big (
    .clk(clk), .rst(b_rst), .sample_in(b_sample), .ofm_in(b_ofm),
    .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata),
    .busy(b_busy), .ram_feedback(b_fb), .overrun(b_ov)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Observed writes of the small instance
  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t obs [$];
  int  wcnt [16];

  always @(negedge clk) begin
    if (s_we === 1'b1) begin
      obs.push_back('{a: s_addr, d: s_wdata});
      wcnt[s_addr]++;
    end
  end

  // Full-layer reference for the big instance: write n belongs to pixel n/256, channel n%256.
  logic [15:0] b_cur [0:B_DSP-1];
  int          b_n = 0;
  int          b_bad = 0;
  logic [15:0] b_last = '0;

  always @(negedge clk) begin
    if (b_we === 1'b1) begin
      int pix, ch;
      pix = b_n / B_DSP;
      ch  = b_n % B_DSP;
      if (b_addr !== 16'(ch * B_PIX + pix) || b_wdata !== b_cur[ch]) b_bad++;
      b_last = b_addr;
      b_n++;
    end
  end

  // Directed table: input vector and the writes it must produce, in order.
  typedef struct {
    logic [15:0] ofm      [4];
    logic [3:0]  exp_addr [4];
    logic [15:0] exp_data [4];
  } vec_t;
  vec_t tbl [4];

  task automatic s_reset();
    s_rst    = 1'b1;
    s_sample = 1'b0;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
  endtask

  // Drives a sample for one edge; returns on the negedge right after the capture edge.
  task automatic s_pulse(input logic [15:0] v [4]);
    for (int c = 0; c < 4; c++) s_ofm[c] = v[c];
    s_sample = 1'b1;
    @(negedge clk);
    s_sample = 1'b0;
  endtask

  initial begin
    logic [15:0] va [4];
    logic [15:0] vb [4];
    wr_t         expq [$];
    int          acc, last_edge, e, osz;
    logic        m_ov;

    tbl[0].ofm = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    tbl[0].exp_addr = '{4'd0, 4'd4, 4'd8, 4'd12};
    tbl[0].exp_data = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    tbl[1].ofm = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    tbl[1].exp_addr = '{4'd1, 4'd5, 4'd9, 4'd13};
    tbl[1].exp_data = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    tbl[2].ofm = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    tbl[2].exp_addr = '{4'd2, 4'd6, 4'd10, 4'd14};
    tbl[2].exp_data = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    tbl[3].ofm = '{16'h0300, 16'h0301, 16'h0302, 16'h0303};
    tbl[3].exp_addr = '{4'd3, 4'd7, 4'd11, 4'd15};
    tbl[3].exp_data = '{16'h0300, 16'h0301, 16'h0302, 16'h0303};

    s_rst = 1'b1; s_sample = 1'b0;
    b_rst = 1'b1; b_sample = 1'b0;
    for (int c = 0; c < S_DSP; c++) s_ofm[c] = '0;
    for (int c = 0; c < B_DSP; c++) begin b_ofm[c] = '0; b_cur[c] = '0; end
    for (int a = 0; a < 16; a++) wcnt[a] = 0;

    // Reset and idle
    s_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {s_we, s_busy, s_fb, s_ov}, 4'b0000);
    end

    // Table-driven full layer, then the extra trailing pulse
    for (int a = 0; a < 16; a++) wcnt[a] = 0;
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      s_pulse(tbl[i].ofm);
      chk("busy_after_capture", s_busy, 1'b1);
      chk("no_write_on_capture", s_we, 1'b0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("tbl_we", s_we, 1'b1);
        chk("tbl_addr", s_addr, tbl[i].exp_addr[k]);
        chk("tbl_data", s_wdata, tbl[i].exp_data[k]);
      end
      chk("busy_after_drain", s_busy, 1'b0);
      @(negedge clk);
      chk("we_after_drain", s_we, 1'b0);
      chk("feedback_progress", s_fb, (i == 3) ? 1'b1 : 1'b0);
      repeat (4) @(negedge clk);
    end
    for (int a = 0; a < 16; a++) chk("write_once", wcnt[a], 1);
    osz = obs.size();
    s_pulse(tbl[0].ofm);
    repeat (10) @(negedge clk);
    chk("extra_pulse_no_write", obs.size(), osz);
    chk("extra_pulse_no_overrun", s_ov, 1'b0);
    chk("feedback_held", s_fb, 1'b1);

    // Second sample two edges into a drain
    s_reset();
    chk("overrun_cleared_by_reset", s_ov, 1'b0);
    chk("feedback_cleared_by_reset", s_fb, 1'b0);
    obs.delete();
    va = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    vb = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
    s_pulse(va);
    @(negedge clk);
    chk("overrun_before_collision", s_ov, 1'b0);
    s_pulse(vb);
    @(negedge clk);
    chk("overrun_set", s_ov, 1'b1);
    repeat (6) @(negedge clk);
    chk("overrun_write_count", obs.size(), 4);
    for (int k = 0; k < 4 && k < obs.size(); k++)
      chk("overrun_first_vector", obs[k], {4'(k * 4), va[k]});
    chk("overrun_sticky", s_ov, 1'b1);

    // Reset in the middle of a drain
    s_reset();
    s_pulse(va);
    repeat (8) @(negedge clk);
    s_pulse(vb);
    @(negedge clk);
    chk("drain_started", s_we, 1'b1);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    chk("abort_we", s_we, 1'b0);
    chk("abort_busy", s_busy, 1'b0);
    @(negedge clk);
    s_pulse(va);
    @(negedge clk);
    chk("restart_we", s_we, 1'b1);
    chk("restart_addr", s_addr, 4'd0);
    chk("restart_data", s_wdata, va[0]);
    repeat (6) @(negedge clk);

    // Randomized spacing and data against the reference model
    s_reset();
    obs.delete();
    expq.delete();
    acc = 0;
    last_edge = -1000;
    m_ov = 1'b0;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(1, 7)) @(negedge clk);
      for (int c = 0; c < 4; c++) va[c] = 16'($urandom);
      e = cyc + 1;
      if (e - last_edge <= S_DSP) begin
        m_ov = 1'b1;
      end else if (acc < S_PIX) begin
        for (int c = 0; c < 4; c++) expq.push_back('{a: 4'(c * S_PIX + acc), d: va[c]});
        last_edge = e;
        acc++;
      end
      s_pulse(va);
    end
    repeat (10) @(negedge clk);
    chk("rand_write_count", obs.size(), expq.size());
    for (int k = 0; k < expq.size() && k < obs.size(); k++)
      chk("rand_write", obs[k], expq[k]);
    chk("rand_overrun", s_ov, m_ov);
    chk("rand_feedback", s_fb, (acc == S_PIX) ? 1'b1 : 1'b0);

    // Default size: a full layer plus the trailing pulse
    b_rst = 1'b1;
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    chk("big_reset", {b_we, b_busy, b_fb, b_ov}, 4'b0000);
    for (int p = 0; p < B_PIX + 1; p++) begin
      if (p == B_PIX - 1) chk("big_feedback_early", b_fb, 1'b0);
      for (int c = 0; c < B_DSP; c++) begin
        b_ofm[c] = 16'($urandom);
        b_cur[c] = b_ofm[c];
      end
      b_sample = 1'b1;
      @(negedge clk);
      b_sample = 1'b0;
      repeat (259) @(negedge clk);
    end
    chk("big_write_count", b_n, B_DSP * B_PIX);
    chk("big_write_errors", b_bad, 0);
    chk("big_last_addr", b_last, 16'hFFFF);
    chk("big_feedback", b_fb, 1'b1);
    chk("big_overrun", b_ov, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
